// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: write-back source
// encodings, default write-back states of the control FSM and the clear FSM states.
package regfile_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    localparam logic [3:0] DEF_ST_WB_A = 4'b0110;
    localparam logic [3:0] DEF_ST_WB_B = 4'b0111;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks cnt over every register index once,
// then parks in READY until the next reset.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy_o,
    output logic          clr_en_o,
    output logic [AW-1:0] cnt_o
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;

    // cnt freezes on the last index so READY never wraps back into a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            if (cnt_q == LAST) begin
                state_q <= READY;
            end else begin
                cnt_q <= cnt_q + AW'(1);
            end
        end
    end

    assign busy_o   = (state_q == CLEAR);
    assign clr_en_o = (state_q == CLEAR) && !rst;
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Integer register file for the multi-cycle datapath: write-back mux, hardwired x0,
// write-to-read bypass, hardware clear after reset and a registered debug read port.
module banco_registradores_param
    import regfile_pkg::*;
#(
    parameter int         XLEN    = 32,
    parameter int         NREGS   = 32,
    parameter int         AW      = $clog2(NREGS),
    parameter logic [3:0] ST_WB_A = DEF_ST_WB_A,
    parameter logic [3:0] ST_WB_B = DEF_ST_WB_B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      estado,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic            regwrite,
    input  logic [1:0]      wbsel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] readdata1,
    output logic [XLEN-1:0] readdata2,
    output logic            busy,
    input  logic            dbg_req,
    input  logic [AW-1:0]   dbg_addr,
    output logic            dbg_valid,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            clr_en;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] wdata_d;
    logic            wr_en;
    logic            dbg_valid_q;
    logic [XLEN-1:0] dbg_data_q;

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy_o   (busy),
        .clr_en_o (clr_en),
        .cnt_o    (clr_cnt)
    );

    always_comb begin
        case (wbsel)
            WB_ALU:  wdata_d = alu_result;
            WB_MEM:  wdata_d = mem_data;
            WB_PC4:  wdata_d = pc_plus4;
            default: wdata_d = '0;
        endcase
    end

    assign wr_en = !busy && regwrite && (estado == ST_WB_A || estado == ST_WB_B)
                   && (wbsel != WB_NONE) && (rd != '0);

    always_ff @(posedge clk) begin
        if (clr_en) begin
            regs_q[clr_cnt] <= '0;
        end else if (wr_en) begin
            regs_q[rd] <= wdata_d;
        end
    end

    // wr_en already excludes rd==0, so x0 never picks up the bypass
    always_comb begin
        readdata1 = regs_q[rs1];
        readdata2 = regs_q[rs2];
        if (wr_en && rs1 == rd) readdata1 = wdata_d;
        if (wr_en && rs2 == rd) readdata2 = wdata_d;
        if (busy || rs1 == '0)  readdata1 = '0;
        if (busy || rs2 == '0)  readdata2 = '0;
    end

    // Debug port samples the array before this edge's write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            dbg_valid_q <= dbg_req;
            if (dbg_req) begin
                dbg_data_q <= (busy || dbg_addr == '0) ? '0 : regs_q[dbg_addr];
            end
        end
    end

    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Self-checking bench for banco_registradores_param: a reference model of the array
// predicts reads, and a scoreboard queue holds expected debug responses.
module tb_banco_registradores_param;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  estado;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite;
    logic [1:0]  wbsel;
    logic [31:0] alu_result, mem_data, pc_plus4;
    logic [31:0] readdata1, readdata2;
    logic        busy;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_valid;
    logic [31:0] dbg_data;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] model [32];
    bit          modelBusy;
    bit          started = 0;
    logic        reqSampled = 1'b0;
    logic [31:0] sbQueue [$];

    banco_registradores_param #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .estado     (estado),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .regwrite   (regwrite),
        .wbsel      (wbsel),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .readdata1  (readdata1),
        .readdata2  (readdata2),
        .busy       (busy),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        else
            passCount++;
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] a, input logic wen,
                                            input logic [31:0] wd, input logic [4:0] rdA);
        if (modelBusy || a == 5'd0) return 32'h0;
        if (wen && a == rdA) return wd;
        return model[a];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // A debug request observed at an edge (outside reset) must be answered on the next cycle
    always @(posedge clk) reqSampled <= dbg_req && !rst;

    always @(negedge clk) begin
        if (started) begin
            checkOutput("dbg_valid", {31'b0, dbg_valid}, {31'b0, reqSampled});
            if (dbg_valid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sb_underflow", sbQueue.size(), 1);
                end else begin
                    checkOutput("dbg_data", dbg_data, sbQueue.pop_front());
                end
            end
        end
    end

    task automatic issueDbg(input logic [4:0] a);
        dbg_addr = a;
        dbg_req  = 1'b1;
        sbQueue.push_back((modelBusy || a == 5'd0) ? 32'h0 : model[a]);
    endtask

    task automatic dbgRead(input logic [4:0] a);
        issueDbg(a);
        cycle();
        dbg_req = 1'b0;
    endtask

    task automatic dbgSweep();
        for (int a = 0; a < 32; a++) begin
            issueDbg(5'(a));
            cycle();
        end
        dbg_req = 1'b0;
        cycle();
    endtask

    task automatic applyStimulus(input logic [3:0] est, input logic we, input logic [1:0] sel,
                                 input logic [4:0] rdA, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [31:0] pc4,
                                 input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] wd;
        logic        wen;
        estado = est; regwrite = we; wbsel = sel; rd = rdA;
        alu_result = alu; mem_data = mem; pc_plus4 = pc4; rs1 = a1; rs2 = a2;
        case (sel)
            2'b00:   wd = alu;
            2'b01:   wd = mem;
            2'b10:   wd = pc4;
            default: wd = 32'h0;
        endcase
        wen = !modelBusy && we && (est == 4'b0110 || est == 4'b0111)
              && sel != 2'b11 && rdA != 5'd0;
        #1;
        checkOutput("wr_rd1", readdata1, expRead(a1, wen, wd, rdA));
        checkOutput("wr_rd2", readdata2, expRead(a2, wen, wd, rdA));
        @(posedge clk);
        #1;
        if (wen) model[rdA] = wd;
        regwrite = 1'b0;
        wbsel    = WB_NONE;
    endtask

    task automatic readCheck(input logic [4:0] a1, input logic [4:0] a2);
        rs1 = a1;
        rs2 = a2;
        #1;
        checkOutput("rd1", readdata1, expRead(a1, 1'b0, 32'h0, 5'd0));
        checkOutput("rd2", readdata2, expRead(a2, 1'b0, 32'h0, 5'd0));
    endtask

    // Call right after rst is released: busy must hold for exactly 32 cycles
    task automatic runClear(input bit tryWrites);
        modelBusy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checkOutput("busy_clear", {31'b0, busy}, 32'h1);
            if (tryWrites && (i % 8) == 3)
                applyStimulus(4'b0110, 1'b1, WB_ALU, 5'(i + 1), 32'hBAD0 + i, 32'h0, 32'h0,
                              5'(i + 1), 5'(i + 1));
            else
                cycle();
        end
        modelBusy = 1'b0;
        checkOutput("busy_done", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; estado = 4'd0; rs1 = 5'd5; rs2 = 5'd31; rd = 5'd0;
        regwrite = 1'b0; wbsel = WB_NONE; alu_result = 32'h0; mem_data = 32'h0;
        pc_plus4 = 32'h0; dbg_req = 1'b0; dbg_addr = 5'd0;
        modelBusy = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        cycle();
        cycle();
        started = 1'b1;
        checkOutput("rst_busy",      {31'b0, busy},      32'h1);
        checkOutput("rst_dbg_valid", {31'b0, dbg_valid}, 32'h0);
        checkOutput("rst_dbg_data",  dbg_data,           32'h0);
        checkOutput("rst_rd1",       readdata1,          32'h0);
        rst = 1'b0;
        runClear(1'b0);
        readCheck(5'd5, 5'd31);
        dbgSweep();

        applyStimulus(4'b0110, 1'b1, WB_ALU, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 5'd3);
        readCheck(5'd5, 5'd3);
        applyStimulus(4'b0111, 1'b1, WB_MEM, 5'd7, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd7, 5'd5);
        applyStimulus(4'b0111, 1'b1, WB_PC4, 5'd1, 32'h0, 32'h0, 32'h0000_0040, 5'd1, 5'd7);
        readCheck(5'd7, 5'd1);
        applyStimulus(4'b0011, 1'b1, WB_ALU, 5'd7, 32'h1111_1111, 32'h0, 32'h0, 5'd7, 5'd1);
        applyStimulus(4'b0110, 1'b1, WB_NONE, 5'd1, 32'h2222_2222, 32'h3333_3333,
                      32'h4444_4444, 5'd1, 5'd7);
        applyStimulus(4'b0110, 1'b0, WB_ALU, 5'd5, 32'h5555_5555, 32'h0, 32'h0, 5'd5, 5'd5);
        applyStimulus(4'b0110, 1'b1, WB_ALU, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
        readCheck(5'd7, 5'd1);
        readCheck(5'd5, 5'd0);
        dbgRead(5'd0);
        dbgRead(5'd7);
        dbgRead(5'd1);

        applyStimulus(4'b0110, 1'b1, WB_MEM, 5'd9, 32'h0, 32'hA5A5_5A5A, 32'h0, 5'd9, 5'd9);
        for (int n = 0; n < 8; n++) begin
            logic [3:0] est;
            est = ($urandom_range(0, 3) == 0) ? 4'b0101 : (($urandom_range(0, 1) == 1) ? 4'b0110 : 4'b0111);
            applyStimulus(est, 1'b1, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)),
                          $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
        end

        // Debug request in the same cycle as a write to the same register
        applyStimulus(4'b0110, 1'b1, WB_ALU, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 5'd5);
        issueDbg(5'd5);
        applyStimulus(4'b0110, 1'b1, WB_ALU, 5'd5, 32'h0000_0099, 32'h0, 32'h0, 5'd5, 5'd5);
        dbgRead(5'd5);
        dbgSweep();

        // Reset mid-operation, then again part-way through the clear
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        modelBusy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("busy_partial", {31'b0, busy}, 32'h1);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        runClear(1'b1);
        readCheck(5'd5, 5'd7);
        readCheck(5'd4, 5'd12);
        dbgSweep();

        cycle();
        cycle();
        checkOutput("sb_drain", sbQueue.size(), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
